// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared constants for the multiplier datapath: default product and byte
// widths, and the state encoding of the result unloader FSM.
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int DEFAULT_PW = 32;  // product width in bits
  localparam int DEFAULT_BW = 8;   // presented byte width in bits

  // Result unloader state encoding.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_SHOW    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage : mult_pkg

// File: rtl/result_unloader.sv
// -----------------------------------------------------------------------------
// result_unloader
// Captures a multiplier product when the controller pulses ready, then
// presents it one byte at a time (least significant first) to an operator
// who steps through the bytes with press/release cycles on get. A single
// done pulse follows the release of the last byte.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous, active-high reset
//   ready    : one-cycle capture pulse; product is valid in the same cycle
//   product  : multiplier result, PW bits
//   get      : operator strobe (already synchronized and debounced)
//   data_out : presented byte while valid, 0 otherwise
//   byte_sel : index of the presented byte, 0 = least significant
//   valid    : high while data_out holds a presented byte
//   busy     : high from capture until the unload completes
//   done     : one-cycle pulse after the last byte is released
//   overrun  : (only with RESULT_UNLOADER_OVERRUN_EN) sticky flag, set by a
//              ready pulse arriving outside IDLE, cleared by rst or by the
//              next accepted capture
//
// Configuration macro: RESULT_UNLOADER_OVERRUN_EN
// -----------------------------------------------------------------------------
module result_unloader
  import mult_pkg::*;
#(
  parameter int PW = DEFAULT_PW,
  parameter int BW = DEFAULT_BW,
  localparam int NB = PW / BW,
  localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready,
  input  logic [PW-1:0] product,
  input  logic          get,
  output logic [BW-1:0] data_out,
  output logic [IW-1:0] byte_sel,
  output logic          valid,
  output logic          busy,
  output logic          done
`ifdef RESULT_UNLOADER_OVERRUN_EN
  ,
  output logic          overrun
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [1:0]    state_q;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] cap_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples its inputs as they were before the edge.
  // NOTE: the capture register is reset too, so a reset leaves no trace of a
  // previous product anywhere in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A coincident get is deliberately not looked at here; it will
          // advance WAIT_HI on the following edge if still held.
          if (ready) begin
            cap_q   <= product;
            idx_q   <= '0;
            state_q <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (get) state_q <= S_SHOW;
        end
        S_SHOW: begin
          if (!get) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= S_WAIT_HI;
            end
          end
        end
        default: begin  // S_DONE
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RESULT_UNLOADER_OVERRUN_EN
  // Capture and a rejected ready are mutually exclusive (IDLE vs not IDLE),
  // so set and clear never compete.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (ready) begin
      overrun <= (state_q != S_IDLE) ? 1'b1 : 1'b0;
    end
  end
`endif

  // Byte multiplexer: outputs depend on registered state and index only.
  // NOTE: data_out gets a default before the conditional select so the
  // combinational block cannot infer a latch.
  always_comb begin
    data_out = '0;
    if (state_q == S_SHOW) begin
      for (int i = 0; i < NB; i++) begin
        if (idx_q == IW'(i)) data_out = cap_q[i*BW +: BW];
      end
    end
  end

  assign byte_sel = idx_q;
  assign valid    = (state_q == S_SHOW);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule : result_unloader
